// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: accepts one load or store at a time,
// inserts WAIT_CYCLES wait states, then presents a one-cycle response while stalling the pipe.
module dmem_responder #(
   parameter int DSIZE       = 32,
   parameter int ISIZE       = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_wen,
   input  logic [ISIZE-1:0] req_addr,
   input  logic [DSIZE-1:0] req_wdata,
   output logic             req_ready,
   output logic             resp_valid,
   output logic [DSIZE-1:0] resp_rdata,
   output logic             addr_err,
   output logic             stall
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic             wen;
      logic [ISIZE-1:0] addr;
      logic [DSIZE-1:0] wdata;
   } req_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   req_t             req_q, req_cur;
   logic             commit;
   logic             in_range;
   logic [AW-1:0]    idx;
   logic             err_q;
   logic [DSIZE-1:0] mem [DEPTH];

   // With zero wait states the commit happens on the accepting edge, so the
   // live request must be used before it has been latched.
   always_comb begin
      if (state == IDLE) begin
         req_cur.wen   = req_wen;
         req_cur.addr  = req_addr;
         req_cur.wdata = req_wdata;
      end else begin
         req_cur = req_q;
      end
      in_range = (req_cur.addr >> AW) == '0;
      idx      = req_cur.addr[AW-1:0];
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WAIT_LD;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign addr_err   = resp_valid & err_q;
   assign stall      = ((state == IDLE) & req_valid) | (state == WAIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_q      <= '0;
         resp_rdata <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if ((state == IDLE) && req_valid)
            req_q <= req_cur;
         if (commit) begin
            resp_rdata <= req_cur.wen ? req_cur.wdata : (in_range ? mem[idx] : '0);
            err_q      <= ~in_range;
         end
      end
   end

   // Storage is deliberately left out of reset; only committed stores land here.
   always_ff @(posedge clk) begin
      if (commit && req_cur.wen && in_range)
         mem[idx] <= req_cur.wdata;
   end

endmodule
